// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the serial pattern detector and for other
// saturating counters in this codebase.
package seq_det_pkg;

    localparam int         MAX_PAT_W       = 16;
    localparam logic [2:0] DEFAULT_PATTERN = 3'b110;

    // Adds one to value and stops at all-ones for the given width (1..32).
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int width);
        logic [31:0] max_val;
        max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value >= max_val) ? max_val : value + 32'd1;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter. A clear that arrives together with an increment
// loads 1, so the coincident event still gets counted.
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    always_ff @(posedge clk) begin
        if (RESET) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc) begin
            count <= CNT_W'(sat_inc(32'(count), CNT_W));
        end
    end

    assign sat = &count;

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-pattern detector with selectable overlap, Mealy or registered
// match flag, input-enable qualifier and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int PAT_W   = 3,
    parameter     PATTERN = DEFAULT_PATTERN,
    parameter int OVERLAP = 1,
    parameter int REG_OUT = 0,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             X,
    input  logic             en,
    input  logic             clear_cnt,
    output logic             Z,
    output logic [CNT_W-1:0] match_cnt,
    output logic             cnt_sat
);

    if (PAT_W < 2 || PAT_W > MAX_PAT_W || $bits(PATTERN) != PAT_W
        || CNT_W < 1 || CNT_W > 32) begin : g_bad_cfg
        $error("seq_detector_param: PATTERN width must equal PAT_W (2..16), CNT_W 1..32");
    end

    localparam int               FW       = $clog2(PAT_W);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W - 1);
    localparam logic [PAT_W-1:0] PAT_VAL  = PATTERN;

    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] window;
    logic             hit;

    assign window = {hist, X};
    assign hit    = en && (fill == FILL_MAX) && (window == PAT_VAL);

    always_ff @(posedge clk) begin
        if (RESET) begin
            hist <= '0;
            fill <= '0;
        end else if (en) begin
            hist <= window[PAT_W-2:0];
            // Non-overlap restarts empty so the matched bits cannot be reused.
            if (hit && OVERLAP == 0) begin
                fill <= '0;
            end else if (fill != FILL_MAX) begin
                fill <= fill + FW'(1);
            end
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic z_q;
        always_ff @(posedge clk) begin
            if (RESET) begin
                z_q <= 1'b0;
            end else begin
                z_q <= hit;
            end
        end
        assign Z = z_q;
    end else begin : g_mealy_out
        assign Z = hit & ~RESET;
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk  (clk),
        .RESET(RESET),
        .inc  (hit),
        .clr  (clear_cnt),
        .count(match_cnt),
        .sat  (cnt_sat)
    );

endmodule
